reservation_param_entry: RTL and testbench

Single reservation-station entry for the scheduler, parametrised in data width, tag widths and number of Common Data Bus (CDB) channels. It holds two source operands and one condition-flag operand, and snoops all CDB channels for the results it is waiting on. It raises a ready indication once both sources, the flags and the in-order execution pointer are all satisfied. Unlike the single-source ALU0 entry, an entry that issues can be refilled in the same cycle, so a slot sustains one instruction per clock. Several entries are instantiated per execution unit behind an issue selector.

---
 rtl/reservation_param_entry.sv | 255 +++++++++++++++++++++++++
 tb/tb_reservation_param_entry.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/reservation_param_entry.sv
// Single reservation-station entry with two source operands and a flag operand.
// The entry snoops every CDB channel for pending operands. It reports ready once
// both sources, the flag and the execution-order pointer are satisfied. Issue and
// reload can happen in the same cycle, so one slot can hold a new instruction
// every clock.
module reservation_param_entry #(
  parameter int          P_DATA_W = 32,
  parameter int          P_TAG_W  = 6,
  parameter int          P_FTAG_W = 4,
  parameter int          P_FLAG_W = 5,
  parameter int          P_CMD_W  = 5,
  parameter int          P_PTR_W  = 4,
  parameter int          P_CDB_N  = 3,
  parameter logic [3:0]  P_CC_AL  = 4'h0
) (
  input  logic                           iCLOCK,
  input  logic                           inRESET,
  input  logic                           iREMOVE_VALID,
  input  logic                           iEXOUT_VALID,
  input  logic                           iREGIST_VALID,
  input  logic [P_CMD_W-1:0]             iREGIST_CMD,
  input  logic [3:0]                     iREGIST_CC,
  input  logic                           iREGIST_FLAGS_VALID,
  input  logic [P_FLAG_W-1:0]            iREGIST_FLAGS,
  input  logic                           iREGIST_SRC0_VALID,
  input  logic [P_DATA_W-1:0]            iREGIST_SRC0_DATA,
  input  logic [P_TAG_W-1:0]             iREGIST_SRC0_TAG,
  input  logic                           iREGIST_SRC1_VALID,
  input  logic [P_DATA_W-1:0]            iREGIST_SRC1_DATA,
  input  logic [P_TAG_W-1:0]             iREGIST_SRC1_TAG,
  input  logic [31:0]                    iREGIST_PC,
  input  logic [P_TAG_W-1:0]             iREGIST_DESTINATION_REGNAME,
  input  logic [5:0]                     iREGIST_COMMIT_TAG,
  input  logic [P_PTR_W-1:0]             iREGIST_EX_REGIST_POINTER,
  input  logic [P_PTR_W-1:0]             iEX_EXECUTION_POINTER,
  input  logic [P_CDB_N-1:0]             iCDB_VALID,
  input  logic [P_CDB_N-1:0]             iCDB_WRITEBACK,
  input  logic [P_CDB_N*P_TAG_W-1:0]     iCDB_DEST_TAG,
  input  logic [P_CDB_N*P_DATA_W-1:0]    iCDB_DATA,
  input  logic [P_CDB_N-1:0]             iCDB_FLAG_VALID,
  input  logic [P_CDB_N*P_FTAG_W-1:0]    iCDB_FLAG_TAG,
  input  logic [P_CDB_N*P_FLAG_W-1:0]    iCDB_FLAG,
  output logic                           oINFO_ENTRY_VALID,
  output logic                           oINFO_MATCHING,
  output logic [P_CMD_W-1:0]             oINFO_CMD,
  output logic [3:0]                     oINFO_CC,
  output logic                           oINFO_FLAG_VALID,
  output logic [P_FLAG_W-1:0]            oINFO_FLAG,
  output logic                           oINFO_SRC0_VALID,
  output logic [P_DATA_W-1:0]            oINFO_SRC0,
  output logic                           oINFO_SRC1_VALID,
  output logic [P_DATA_W-1:0]            oINFO_SRC1,
  output logic [31:0]                    oINFO_PC,
  output logic [P_TAG_W-1:0]             oINFO_DESTINATION_REGNAME,
  output logic [5:0]                     oINFO_COMMIT_TAG
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [P_CMD_W-1:0]    cmd_q, cmd_d;
  logic [3:0]            cc_q, cc_d;
  logic                  flag_valid_q, flag_valid_d;
  logic [P_FLAG_W-1:0]   flag_q, flag_d;
  logic                  src0_valid_q, src0_valid_d;
  logic [P_DATA_W-1:0]   src0_q, src0_d;
  logic                  src1_valid_q, src1_valid_d;
  logic [P_DATA_W-1:0]   src1_q, src1_d;
  logic [31:0]           pc_q, pc_d;
  logic [P_TAG_W-1:0]    dest_q, dest_d;
  logic [5:0]            commit_q, commit_d;
  logic [P_PTR_W-1:0]    ptr_q, ptr_d;
  logic                  ptr_match_q, ptr_match_d;

  // Search loops run from the top channel down, so the lowest matching channel is kept.
  function automatic logic [P_DATA_W:0] src_lookup(
    input logic [P_TAG_W-1:0]          tag,
    input logic [P_CDB_N-1:0]          vld,
    input logic [P_CDB_N*P_TAG_W-1:0]  tags,
    input logic [P_CDB_N*P_DATA_W-1:0] data
  );
    logic [P_DATA_W:0] r;
    r = '0;
    for (int k = P_CDB_N - 1; k >= 0; k--)
      if (vld[k] && (tags[k*P_TAG_W +: P_TAG_W] == tag))
        r = {1'b1, data[k*P_DATA_W +: P_DATA_W]};
    return r;
  endfunction

  function automatic logic [P_FLAG_W:0] flag_lookup(
    input logic [P_FTAG_W-1:0]          tag,
    input logic [P_CDB_N-1:0]           vld,
    input logic [P_CDB_N*P_FTAG_W-1:0]  tags,
    input logic [P_CDB_N*P_FLAG_W-1:0]  data
  );
    logic [P_FLAG_W:0] r;
    r = '0;
    for (int k = P_CDB_N - 1; k >= 0; k--)
      if (vld[k] && (tags[k*P_FTAG_W +: P_FTAG_W] == tag))
        r = {1'b1, data[k*P_FLAG_W +: P_FLAG_W]};
    return r;
  endfunction

  logic [P_CDB_N-1:0] wb_vld, fl_vld;
  logic [P_DATA_W:0]  ld_s0, ld_s1, wt_s0, wt_s1;
  logic [P_FLAG_W:0]  ld_fl, wt_fl;

  // Bypass lookups for the incoming instruction and wakeup lookups for the stored tags.
  always_comb begin
    wb_vld = iCDB_VALID & iCDB_WRITEBACK;
    fl_vld = iCDB_VALID & iCDB_FLAG_VALID;
    ld_s0  = src_lookup(iREGIST_SRC0_TAG, wb_vld, iCDB_DEST_TAG, iCDB_DATA);
    ld_s1  = src_lookup(iREGIST_SRC1_TAG, wb_vld, iCDB_DEST_TAG, iCDB_DATA);
    wt_s0  = src_lookup(src0_q[P_TAG_W-1:0], wb_vld, iCDB_DEST_TAG, iCDB_DATA);
    wt_s1  = src_lookup(src1_q[P_TAG_W-1:0], wb_vld, iCDB_DEST_TAG, iCDB_DATA);
    ld_fl  = flag_lookup(iREGIST_FLAGS[P_FTAG_W-1:0], fl_vld, iCDB_FLAG_TAG, iCDB_FLAG);
    wt_fl  = flag_lookup(flag_q[P_FTAG_W-1:0], fl_vld, iCDB_FLAG_TAG, iCDB_FLAG);
  end

  // Next-state: remove > issue+load (reload) > issue > load-when-empty > wakeup.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    cc_d         = cc_q;
    flag_valid_d = flag_valid_q;
    flag_d       = flag_q;
    src0_valid_d = src0_valid_q;
    src0_d       = src0_q;
    src1_valid_d = src1_valid_q;
    src1_d       = src1_q;
    pc_d         = pc_q;
    dest_d       = dest_q;
    commit_d     = commit_q;
    ptr_d        = ptr_q;
    ptr_match_d  = ptr_match_q;

    if (iREMOVE_VALID || (iEXOUT_VALID && !iREGIST_VALID)) begin
      state_d      = ST_EMPTY;
      cmd_d        = '0;
      cc_d         = '0;
      flag_valid_d = 1'b0;
      flag_d       = '0;
      src0_valid_d = 1'b0;
      src0_d       = '0;
      src1_valid_d = 1'b0;
      src1_d       = '0;
      pc_d         = '0;
      dest_d       = '0;
      commit_d     = '0;
      ptr_d        = '0;
      ptr_match_d  = 1'b0;
    end else if (iREGIST_VALID && (iEXOUT_VALID || state_q == ST_EMPTY)) begin
      state_d  = ST_WAIT;
      cmd_d    = iREGIST_CMD;
      cc_d     = iREGIST_CC;
      pc_d     = iREGIST_PC;
      dest_d   = iREGIST_DESTINATION_REGNAME;
      commit_d = iREGIST_COMMIT_TAG;
      ptr_d    = iREGIST_EX_REGIST_POINTER;
      ptr_match_d = (iREGIST_EX_REGIST_POINTER == iEX_EXECUTION_POINTER);
      if (iREGIST_SRC0_VALID) begin
        src0_valid_d = 1'b1;
        src0_d       = iREGIST_SRC0_DATA;
      end else begin
        src0_valid_d = ld_s0[P_DATA_W];
        src0_d       = ld_s0[P_DATA_W] ? ld_s0[P_DATA_W-1:0]
                                       : {{(P_DATA_W-P_TAG_W){1'b0}}, iREGIST_SRC0_TAG};
      end
      if (iREGIST_SRC1_VALID) begin
        src1_valid_d = 1'b1;
        src1_d       = iREGIST_SRC1_DATA;
      end else begin
        src1_valid_d = ld_s1[P_DATA_W];
        src1_d       = ld_s1[P_DATA_W] ? ld_s1[P_DATA_W-1:0]
                                       : {{(P_DATA_W-P_TAG_W){1'b0}}, iREGIST_SRC1_TAG};
      end
      if (iREGIST_CC == P_CC_AL) begin
        flag_valid_d = 1'b1;
        flag_d       = '0;
      end else if (iREGIST_FLAGS_VALID) begin
        flag_valid_d = 1'b1;
        flag_d       = iREGIST_FLAGS;
      end else begin
        flag_valid_d = ld_fl[P_FLAG_W];
        flag_d       = ld_fl[P_FLAG_W] ? ld_fl[P_FLAG_W-1:0] : iREGIST_FLAGS;
      end
    end else if (state_q == ST_WAIT) begin
      if (!src0_valid_q && wt_s0[P_DATA_W]) begin
        src0_valid_d = 1'b1;
        src0_d       = wt_s0[P_DATA_W-1:0];
      end
      if (!src1_valid_q && wt_s1[P_DATA_W]) begin
        src1_valid_d = 1'b1;
        src1_d       = wt_s1[P_DATA_W-1:0];
      end
      if (!flag_valid_q && wt_fl[P_FLAG_W]) begin
        flag_valid_d = 1'b1;
        flag_d       = wt_fl[P_FLAG_W-1:0];
      end
      if (!ptr_match_q && (ptr_q == iEX_EXECUTION_POINTER))
        ptr_match_d = 1'b1;
    end
  end

  // State and field registers, cleared asynchronously.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q      <= ST_EMPTY;
      cmd_q        <= '0;
      cc_q         <= '0;
      flag_valid_q <= 1'b0;
      flag_q       <= '0;
      src0_valid_q <= 1'b0;
      src0_q       <= '0;
      src1_valid_q <= 1'b0;
      src1_q       <= '0;
      pc_q         <= '0;
      dest_q       <= '0;
      commit_q     <= '0;
      ptr_q        <= '0;
      ptr_match_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      cc_q         <= cc_d;
      flag_valid_q <= flag_valid_d;
      flag_q       <= flag_d;
      src0_valid_q <= src0_valid_d;
      src0_q       <= src0_d;
      src1_valid_q <= src1_valid_d;
      src1_q       <= src1_d;
      pc_q         <= pc_d;
      dest_q       <= dest_d;
      commit_q     <= commit_d;
      ptr_q        <= ptr_d;
      ptr_match_q  <= ptr_match_d;
    end
  end

  assign oINFO_ENTRY_VALID         = (state_q == ST_WAIT);
  assign oINFO_MATCHING            = (state_q == ST_WAIT) & src0_valid_q & src1_valid_q &
                                     flag_valid_q & ptr_match_q;
  assign oINFO_CMD                 = cmd_q;
  assign oINFO_CC                  = cc_q;
  assign oINFO_FLAG_VALID          = flag_valid_q;
  assign oINFO_FLAG                = flag_q;
  assign oINFO_SRC0_VALID          = src0_valid_q;
  assign oINFO_SRC0                = src0_q;
  assign oINFO_SRC1_VALID          = src1_valid_q;
  assign oINFO_SRC1                = src1_q;
  assign oINFO_PC                  = pc_q;
  assign oINFO_DESTINATION_REGNAME = dest_q;
  assign oINFO_COMMIT_TAG          = commit_q;

endmodule

// File: tb/tb_reservation_param_entry.sv
// Directed bench for reservation_param_entry with default parameters.
module tb_reservation_param_entry;
  localparam logic [3:0] CC_AL = 4'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        remove, exout, regist;
  logic [4:0]  cmd;
  logic [3:0]  cc;
  logic        flags_valid;
  logic [4:0]  flags;
  logic        s0v, s1v;
  logic [31:0] s0d, s1d;
  logic [5:0]  s0t, s1t;
  logic [31:0] pc;
  logic [5:0]  dest, commit;
  logic [3:0]  rptr, exptr;
  logic [2:0]  cdb_v, cdb_wb, cdb_fv;
  logic [17:0] cdb_tag;
  logic [95:0] cdb_data;
  logic [11:0] cdb_ftag;
  logic [14:0] cdb_flag;

  logic        o_valid, o_match, o_fv, o_s0v, o_s1v;
  logic [4:0]  o_cmd, o_flag;
  logic [3:0]  o_cc;
  logic [31:0] o_s0, o_s1, o_pc;
  logic [5:0]  o_dest, o_commit;

  int checks = 0;
  int failures = 0;

  reservation_param_entry dut (
    .iCLOCK(clk), .inRESET(rst_n), .iREMOVE_VALID(remove), .iEXOUT_VALID(exout),
    .iREGIST_VALID(regist), .iREGIST_CMD(cmd), .iREGIST_CC(cc),
    .iREGIST_FLAGS_VALID(flags_valid), .iREGIST_FLAGS(flags),
    .iREGIST_SRC0_VALID(s0v), .iREGIST_SRC0_DATA(s0d), .iREGIST_SRC0_TAG(s0t),
    .iREGIST_SRC1_VALID(s1v), .iREGIST_SRC1_DATA(s1d), .iREGIST_SRC1_TAG(s1t),
    .iREGIST_PC(pc), .iREGIST_DESTINATION_REGNAME(dest), .iREGIST_COMMIT_TAG(commit),
    .iREGIST_EX_REGIST_POINTER(rptr), .iEX_EXECUTION_POINTER(exptr),
    .iCDB_VALID(cdb_v), .iCDB_WRITEBACK(cdb_wb), .iCDB_DEST_TAG(cdb_tag),
    .iCDB_DATA(cdb_data), .iCDB_FLAG_VALID(cdb_fv), .iCDB_FLAG_TAG(cdb_ftag),
    .iCDB_FLAG(cdb_flag),
    .oINFO_ENTRY_VALID(o_valid), .oINFO_MATCHING(o_match), .oINFO_CMD(o_cmd),
    .oINFO_CC(o_cc), .oINFO_FLAG_VALID(o_fv), .oINFO_FLAG(o_flag),
    .oINFO_SRC0_VALID(o_s0v), .oINFO_SRC0(o_s0), .oINFO_SRC1_VALID(o_s1v),
    .oINFO_SRC1(o_s1), .oINFO_PC(o_pc), .oINFO_DESTINATION_REGNAME(o_dest),
    .oINFO_COMMIT_TAG(o_commit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    remove = 0; exout = 0; regist = 0; cmd = 0; cc = 0; flags_valid = 0; flags = 0;
    s0v = 0; s1v = 0; s0d = 0; s1d = 0; s0t = 0; s1t = 0; pc = 0; dest = 0; commit = 0;
    rptr = 0; cdb_v = 0; cdb_wb = 0; cdb_fv = 0; cdb_tag = 0; cdb_data = 0;
    cdb_ftag = 0; cdb_flag = 0;
  endtask

  // Inputs change at negedge; outputs are checked at the next negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    idle();
    exptr = 4'h3;
    #12;
    chk("rst_valid", o_valid, 0);
    chk("rst_match", o_match, 0);
    chk("rst_src0", o_s0, 0);
    chk("rst_pc", o_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // fully resolved load, CC always
    regist = 1; s0v = 1; s0d = 5; s1v = 1; s1d = 7; cc = CC_AL; rptr = 4'h3;
    cmd = 5'h0A; pc = 32'h100; dest = 6'h21; commit = 6'h15;
    tick(); idle();
    chk("ld_valid", o_valid, 1);
    chk("ld_match", o_match, 1);
    chk("ld_src0", o_s0, 5);
    chk("ld_src1", o_s1, 7);
    chk("ld_flag", o_flag, 0);
    chk("ld_fv", o_fv, 1);
    chk("ld_dest", o_dest, 6'h21);
    chk("ld_commit", o_commit, 6'h15);
    exout = 1;
    tick(); idle();
    chk("issue_valid", o_valid, 0);
    chk("issue_src0", o_s0, 0);

    // src0 waits on tag 0x12, woken by channel 2
    regist = 1; s0t = 6'h12; s1v = 1; s1d = 1; cc = CC_AL; rptr = 4'h3;
    tick(); idle();
    chk("w_s0v", o_s0v, 0);
    chk("w_s0tag", o_s0, 32'h12);
    chk("w_match0", o_match, 0);
    tick();
    chk("w_idle_s0v", o_s0v, 0);
    cdb_v[2] = 1; cdb_wb[2] = 1; cdb_tag[12 +: 6] = 6'h12; cdb_data[64 +: 32] = 32'hDEADBEEF;
    tick(); idle();
    chk("w_s0v1", o_s0v, 1);
    chk("w_s0data", o_s0, 32'hDEADBEEF);
    chk("w_match1", o_match, 1);
    remove = 1;
    tick(); idle();
    chk("rm_valid", o_valid, 0);

    // same-cycle bypass, ch0 beats ch1; writeback=0 on ch2 does not resolve src0
    regist = 1; s1t = 6'h03; s0t = 6'h05; cc = CC_AL; rptr = 4'h3;
    cdb_v = 3'b111; cdb_wb = 3'b011;
    cdb_tag[0 +: 6] = 6'h03; cdb_tag[6 +: 6] = 6'h03; cdb_tag[12 +: 6] = 6'h05;
    cdb_data[0 +: 32] = 32'h11; cdb_data[32 +: 32] = 32'h22; cdb_data[64 +: 32] = 32'h33;
    tick(); idle();
    chk("byp_s1v", o_s1v, 1);
    chk("byp_s1", o_s1, 32'h11);
    chk("byp_s0v", o_s0v, 0);
    chk("byp_s0tag", o_s0, 32'h05);
    cdb_v[0] = 1; cdb_wb[0] = 0; cdb_tag[0 +: 6] = 6'h05; cdb_data[0 +: 32] = 32'h44;
    tick(); idle();
    chk("nowb_s0v", o_s0v, 0);
    chk("nowb_match", o_match, 0);
    remove = 1;
    tick(); idle();

    // flag wait plus pointer wrap E -> F
    exptr = 4'hE;
    regist = 1; s0v = 1; s1v = 1; cc = 4'h1; flags = 5'h04; rptr = 4'hF;
    tick(); idle();
    chk("fl_fv0", o_fv, 0);
    chk("fl_tag", o_flag, 5'h04);
    chk("fl_match0", o_match, 0);
    cdb_v[1] = 1; cdb_fv[1] = 1; cdb_ftag[4 +: 4] = 4'h4; cdb_flag[5 +: 5] = 5'h1A;
    tick(); idle();
    chk("fl_fv1", o_fv, 1);
    chk("fl_val", o_flag, 5'h1A);
    chk("fl_ptr_wait", o_match, 0);
    exptr = 4'hF;
    tick();
    chk("fl_ptr_match", o_match, 1);

    // issue + load in the same cycle reloads with no bubble
    exout = 1; regist = 1; cmd = 5'h09; pc = 32'h1000; s0v = 1; s1v = 1; cc = CC_AL; rptr = 4'hF;
    tick(); idle();
    chk("rl_valid", o_valid, 1);
    chk("rl_cmd", o_cmd, 5'h09);
    chk("rl_pc", o_pc, 32'h1000);
    chk("rl_match", o_match, 1);

    // load while occupied without issue is ignored
    regist = 1; cmd = 5'h1F; pc = 32'h2000;
    tick(); idle();
    chk("ign_cmd", o_cmd, 5'h09);
    chk("ign_pc", o_pc, 32'h1000);

    // remove + load drops the load
    remove = 1; regist = 1; cmd = 5'h03; s0v = 1; s1v = 1;
    tick(); idle();
    chk("rmld_valid", o_valid, 0);
    chk("rmld_cmd", o_cmd, 0);

    // async reset between edges while waiting
    regist = 1; s0v = 1; s1v = 1; cc = CC_AL; rptr = 4'hF; cmd = 5'h07;
    tick(); idle();
    chk("ar_pre_valid", o_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", o_valid, 0);
    chk("ar_match", o_match, 0);
    chk("ar_cmd", o_cmd, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
